// File: rtl/spi_boot_loader.sv
// SPI (mode 3, MSB first) boot download receiver that turns each received byte
// into a handshaked SRAM write, starting at BOOT_START_ADDR.
module spi_boot_loader #(
    parameter logic [17:0] BOOT_START_ADDR = 18'h0C000,
    parameter logic [17:0] BOOT_END_ADDR   = 18'h0FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm_ss,
    input  logic        arm_sclk,
    input  logic        arm_mosi,
    output logic        wr_req,
    output logic [17:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic        booting,
    output logic        overflow,
    output logic        range_err
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  ss_sync_q, ss_sync_d;
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        wr_req_q, wr_req_d;
    logic [17:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        overflow_q, overflow_d;
    logic        range_err_q, range_err_d;
    logic        exhausted_q, exhausted_d;

    logic        ss_fall, ss_rise, sclk_rise, shift_en, byte_done;
    logic [7:0]  new_byte;

    always_comb begin
        ss_sync_d   = {ss_sync_q[1:0], arm_ss};
        sclk_sync_d = {sclk_sync_q[1:0], arm_sclk};
        mosi_sync_d = {mosi_sync_q[0], arm_mosi};
    end

    // Stage 2 is the synchronised level, stage 3 its previous value.
    assign ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
    // Qualifying with the older ss sample keeps a bit that lands with the ss rise.
    assign shift_en  = (state_q == RECV) && sclk_rise && !ss_sync_q[2];
    assign byte_done = shift_en && (bitcnt_q == 3'd7);
    assign new_byte  = {sr_q[6:0], mosi_sync_q[1]};

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        wr_req_d    = wr_req_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        overflow_d  = overflow_q;
        range_err_d = range_err_q;
        exhausted_d = exhausted_q;

        // An ack retires the pending write before any new byte is considered.
        if (wr_ack && wr_req_q) begin
            wr_req_d = 1'b0;
            if (wr_addr_q == BOOT_END_ADDR) begin
                exhausted_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + 18'd1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (ss_fall) begin
                    state_d     = RECV;
                    bitcnt_d    = 3'd0;
                    wr_addr_d   = BOOT_START_ADDR;
                    exhausted_d = 1'b0;
                end
            end
            RECV: begin
                if (shift_en) begin
                    sr_d     = new_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                if (byte_done) begin
                    if (exhausted_d) begin
                        range_err_d = 1'b1;
                    end else if (wr_req_d) begin
                        overflow_d = 1'b1;
                    end else begin
                        wr_data_d = new_byte;
                        wr_req_d  = 1'b1;
                    end
                end
                if (ss_rise) begin
                    state_d  = DRAIN;
                    bitcnt_d = 3'd0;
                end
            end
            DRAIN: begin
                if (!wr_req_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b111;
            mosi_sync_q <= 2'b00;
            bitcnt_q    <= 3'd0;
            sr_q        <= 8'h00;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= BOOT_START_ADDR;
            wr_data_q   <= 8'h00;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
            range_err_q <= range_err_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign booting   = (state_q != DONE);
    assign overflow  = overflow_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader; the address window is shrunk to 16 bytes
// so full-image and overrun scenarios stay short.
`timescale 1ns/1ps
module tb_spi_boot_loader;

    localparam logic [17:0] START_ADDR = 18'h0C000;
    localparam logic [17:0] END_ADDR   = 18'h0C00F;
    localparam int          NUM_BYTES  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm_ss, arm_sclk, arm_mosi;
    logic        wr_req, wr_ack;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        booting, overflow, range_err;

    int          check_count = 0;
    int          error_count = 0;
    int          write_count = 0;
    logic [17:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        ack_enable;
    int          drop_cycles;

    spi_boot_loader #(
        .BOOT_START_ADDR(START_ADDR),
        .BOOT_END_ADDR  (END_ADDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .arm_ss   (arm_ss),
        .arm_sclk (arm_sclk),
        .arm_mosi (arm_mosi),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .booting  (booting),
        .overflow (overflow),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    // Arbiter model: acknowledges two cycles after it sees wr_req and logs the write.
    initial begin
        int  age;
        logic ack_sent;
        age      = 0;
        ack_sent = 1'b0;
        wr_ack   = 1'b0;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (ack_sent) begin
                ack_sent = 1'b0;
                age      = 0;
            end else if (wr_req && ack_enable) begin
                age++;
                if (age >= 2) begin
                    wr_ack   = 1'b1;
                    ack_sent = 1'b1;
                    if (write_count < 64) begin
                        log_addr[write_count] = wr_addr;
                        log_data[write_count] = wr_data;
                    end
                    write_count++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not end, required end before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Sends the top nbits of value, MSB first: sclk low 2 clk, high 2 clk.
    task automatic applyStimulus(input logic [7:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            arm_sclk = 1'b0;
            arm_mosi = value[7-i];
            @(negedge clk);
            @(negedge clk);
            arm_sclk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic startTransfer();
        @(negedge clk);
        arm_ss = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic endTransfer(output int cycles);
        repeat (3) @(negedge clk);
        arm_ss = 1'b1;
        cycles = 0;
        while (booting && cycles < 30) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic doReset(input string tag);
        arm_ss   = 1'b1;
        arm_sclk = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({tag, "_wr_req"},    32'(wr_req),    32'd0);
        checkOutput({tag, "_wr_addr"},   32'(wr_addr),   32'(START_ADDR));
        checkOutput({tag, "_wr_data"},   32'(wr_data),   32'd0);
        checkOutput({tag, "_booting"},   32'(booting),   32'd1);
        checkOutput({tag, "_overflow"},  32'(overflow),  32'd0);
        checkOutput({tag, "_range_err"}, 32'(range_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        arm_ss     = 1'b1;
        arm_sclk   = 1'b1;
        arm_mosi   = 1'b0;
        ack_enable = 1'b1;
        doReset("rst0");

        // Single byte
        write_count = 0;
        startTransfer();
        applyStimulus(8'hA5, 8);
        repeat (6) @(negedge clk);
        checkOutput("t1_writes",  32'(write_count), 32'd1);
        checkOutput("t1_addr",    32'(log_addr[0]), 32'(START_ADDR));
        checkOutput("t1_data",    32'(log_data[0]), 32'hA5);
        checkOutput("t1_next",    32'(wr_addr),     32'h0C001);
        checkOutput("t1_booting", 32'(booting),     32'd1);
        endTransfer(drop_cycles);
        checkOutput("t1_done",    32'(booting),     32'd0);

        // Full image: every address in the window, in order
        write_count = 0;
        startTransfer();
        checkOutput("t2_restart", 32'(wr_addr), 32'(START_ADDR));
        for (int i = 0; i < NUM_BYTES; i++) applyStimulus(pat(i), 8);
        checkOutput("t2_booting", 32'(booting), 32'd1);
        endTransfer(drop_cycles);
        checkOutput("t2_drop_le8", 32'(drop_cycles <= 8), 32'd1);
        checkOutput("t2_writes",   32'(write_count), 32'(NUM_BYTES));
        for (int i = 0; i < NUM_BYTES; i++) begin
            checkOutput($sformatf("t2_addr%0d", i), 32'(log_addr[i]), 32'(START_ADDR) + 32'(i));
            checkOutput($sformatf("t2_data%0d", i), 32'(log_data[i]), 32'(pat(i)));
        end
        checkOutput("t2_hold",      32'(wr_addr),   32'(END_ADDR));
        checkOutput("t2_overflow",  32'(overflow),  32'd0);
        checkOutput("t2_range_err", 32'(range_err), 32'd0);

        // One byte past the window
        write_count = 0;
        startTransfer();
        for (int i = 0; i <= NUM_BYTES; i++) applyStimulus(pat(i + 100), 8);
        endTransfer(drop_cycles);
        checkOutput("t3_writes",    32'(write_count),   32'(NUM_BYTES));
        checkOutput("t3_last_data", 32'(log_data[NUM_BYTES-1]), 32'(pat(NUM_BYTES - 1 + 100)));
        checkOutput("t3_range_err", 32'(range_err),     32'd1);
        checkOutput("t3_hold",      32'(wr_addr),       32'(END_ADDR));
        checkOutput("t3_overflow",  32'(overflow),      32'd0);
        checkOutput("t3_done",      32'(booting),       32'd0);

        // Withheld ack across two bytes
        doReset("rst4");
        write_count = 0;
        ack_enable  = 1'b0;
        startTransfer();
        applyStimulus(8'h11, 8);
        applyStimulus(8'h22, 8);
        repeat (3) @(negedge clk);
        checkOutput("t4_no_write", 32'(write_count), 32'd0);
        checkOutput("t4_overflow", 32'(overflow),    32'd1);
        checkOutput("t4_pending",  32'(wr_req),      32'd1);
        checkOutput("t4_held",     32'(wr_data),     32'h11);
        ack_enable = 1'b1;
        repeat (6) @(negedge clk);
        endTransfer(drop_cycles);
        checkOutput("t4_writes",   32'(write_count), 32'd1);
        checkOutput("t4_addr",     32'(log_addr[0]), 32'(START_ADDR));
        checkOutput("t4_data",     32'(log_data[0]), 32'h11);
        checkOutput("t4_done",     32'(booting),     32'd0);

        // Partial byte then ss rise
        doReset("rst5");
        write_count = 0;
        startTransfer();
        applyStimulus(8'hE0, 3);
        endTransfer(drop_cycles);
        checkOutput("t5_writes",  32'(write_count), 32'd0);
        checkOutput("t5_wr_req",  32'(wr_req),      32'd0);
        checkOutput("t5_done",    32'(booting),     32'd0);

        // Reset mid-byte, then a clean byte
        startTransfer();
        applyStimulus(8'hFF, 5);
        doReset("rst6");
        write_count = 0;
        startTransfer();
        applyStimulus(8'h3C, 8);
        repeat (6) @(negedge clk);
        checkOutput("t6_writes",  32'(write_count), 32'd1);
        checkOutput("t6_addr",    32'(log_addr[0]), 32'(START_ADDR));
        checkOutput("t6_data",    32'(log_data[0]), 32'h3C);
        checkOutput("t6_booting", 32'(booting),     32'd1);
        endTransfer(drop_cycles);
        checkOutput("t6_done",    32'(booting),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
